// File: rtl/spi_mode_clk_gen_pkg.sv
// Shared types and constants for the SPI mode-aware serial-clock generator.
package spi_mode_clk_gen_pkg;

    localparam int SPI_DIVIDER_LEN = 8;
    localparam int SPI_CNT_LEN     = 6;

    typedef enum logic [1:0] {
        SPI_ST_IDLE = 2'd0,
        SPI_ST_RUN  = 2'd1,
        SPI_ST_DONE = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic sample;
        logic shift;
    } spi_strobe_t;

    // Map an SCLK edge to sample/shift for the latched phase; the final trailing edge never shifts.
    function automatic spi_strobe_t phase_decode(input logic cpha,
                                                 input logic leading,
                                                 input logic last_edge);
        spi_strobe_t s;
        if (cpha == 1'b0) begin
            s.sample = leading;
            s.shift  = !leading && !last_edge;
        end else begin
            s.shift  = leading;
            s.sample = !leading;
        end
        return s;
    endfunction

endpackage

// File: rtl/spi_mode_clk_gen_if.sv
// Control/status bundle between the SPI master FSM (master) and the clock generator (slave).
interface spi_mode_clk_gen_if
    import spi_mode_clk_gen_pkg::*;
#(
    parameter int DIV_W = SPI_DIVIDER_LEN,
    parameter int CNT_W = SPI_CNT_LEN
);
    logic             i_enable;
    logic             i_start;
    logic             i_abort;
    logic             i_cpol;
    logic             i_cpha;
    logic [DIV_W-1:0] i_divider;
    logic [CNT_W-1:0] i_num_bits;
    logic             o_sclk;
    logic             o_pos_edge;
    logic             o_neg_edge;
    logic             o_sample;
    logic             o_shift;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_bit_cnt;

    modport master (
        output i_enable, i_start, i_abort, i_cpol, i_cpha, i_divider, i_num_bits,
        input  o_sclk, o_pos_edge, o_neg_edge, o_sample, o_shift, o_busy, o_done, o_bit_cnt
    );

    modport slave (
        input  i_enable, i_start, i_abort, i_cpol, i_cpha, i_divider, i_num_bits,
        output o_sclk, o_pos_edge, o_neg_edge, o_sample, o_shift, o_busy, o_done, o_bit_cnt
    );
endinterface

// File: rtl/spi_mode_clk_gen_edge_timer.sv
// Half-period counter: counts 0..i_term while enabled and ticks for one cycle at terminal count.
module spi_edge_timer #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_term,
    output logic             o_tick
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == i_term);

    // Next count: clear dominates, wrap on tick, hold while paused.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (o_tick) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (i_en) begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_mode_clk_gen.sv
// SPI SCLK generator for all CPOL/CPHA modes: per-transfer FSM, edge count, phase decode, bit counter.
module spi_mode_clk_gen
    import spi_mode_clk_gen_pkg::*;
#(
    parameter int DIV_W = SPI_DIVIDER_LEN,
    parameter int CNT_W = SPI_CNT_LEN
) (
    input  logic               i_clk,
    input  logic               i_rst,
    spi_mode_clk_gen_if.slave  bus
);
    localparam int KW = CNT_W + 1;

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] num_bits_q, num_bits_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d;
    logic [KW-1:0]    k_q, k_d;
    logic             sclk_q, sclk_d;
    logic             pos_q, pos_d, neg_q, neg_d;
    logic             sample_q, sample_d, shift_q, shift_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             tick_s;
    logic             timer_en_s;
    logic             timer_clr_s;
    logic [KW-1:0]    two_n_s;
    logic [KW-1:0]    k_inc_s;
    spi_strobe_t      strobe_s;

    // k runs 1..2N, so it needs one bit more than the bit count.
    assign two_n_s     = {num_bits_q, 1'b0};
    assign k_inc_s     = k_q + {{CNT_W{1'b0}}, 1'b1};
    assign strobe_s    = phase_decode(cpha_q, k_inc_s[0], k_inc_s == two_n_s);
    assign timer_en_s  = (state_q == SPI_ST_RUN) && bus.i_enable && !bus.i_abort && (k_q != two_n_s);
    assign timer_clr_s = (state_q != SPI_ST_RUN);

    spi_edge_timer #(.DIV_W(DIV_W)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (timer_en_s),
        .i_clr  (timer_clr_s),
        .i_term (div_q),
        .o_tick (tick_s)
    );

    // Next-state and next-output decode; abort outranks any edge due this cycle.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        num_bits_d = num_bits_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        k_d        = k_q;
        sclk_d     = sclk_q;
        pos_d      = 1'b0;
        neg_d      = 1'b0;
        sample_d   = 1'b0;
        shift_d    = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            SPI_ST_IDLE: begin
                sclk_d = bus.i_cpol;
                if (bus.i_start && bus.i_enable) begin
                    div_d      = bus.i_divider;
                    num_bits_d = bus.i_num_bits;
                    cpol_d     = bus.i_cpol;
                    cpha_d     = bus.i_cpha;
                    k_d        = {KW{1'b0}};
                    bit_cnt_d  = {CNT_W{1'b0}};
                    if (bus.i_num_bits == {CNT_W{1'b0}}) begin
                        state_d = SPI_ST_DONE;
                    end else begin
                        state_d = SPI_ST_RUN;
                    end
                end else begin
                    state_d = SPI_ST_IDLE;
                end
            end
            SPI_ST_RUN: begin
                if (bus.i_abort) begin
                    state_d = SPI_ST_IDLE;
                    sclk_d  = cpol_q;
                end else if (k_q == two_n_s) begin
                    state_d = SPI_ST_DONE;
                end else if (tick_s) begin
                    k_d       = k_inc_s;
                    sclk_d    = !sclk_q;
                    pos_d     = !sclk_q;
                    neg_d     = sclk_q;
                    sample_d  = strobe_s.sample;
                    shift_d   = strobe_s.shift;
                    bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, strobe_s.sample};
                end else begin
                    state_d = SPI_ST_RUN;
                end
            end
            SPI_ST_DONE: begin
                state_d = SPI_ST_IDLE;
            end
            default: begin
                state_d = SPI_ST_IDLE;
            end
        endcase
        busy_d = (state_d == SPI_ST_RUN);
        done_d = (state_d == SPI_ST_DONE);
    end

    // State, configuration and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= SPI_ST_IDLE;
            div_q      <= {DIV_W{1'b0}};
            num_bits_q <= {CNT_W{1'b0}};
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            k_q        <= {KW{1'b0}};
            sclk_q     <= 1'b0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
            sample_q   <= 1'b0;
            shift_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bit_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            num_bits_q <= num_bits_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            k_q        <= k_d;
            sclk_q     <= sclk_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            sample_q   <= sample_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign bus.o_sclk     = sclk_q;
    assign bus.o_pos_edge = pos_q;
    assign bus.o_neg_edge = neg_q;
    assign bus.o_sample   = sample_q;
    assign bus.o_shift    = shift_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_bit_cnt  = bit_cnt_q;
endmodule

// File: tb/tb_spi_mode_clk_gen.sv
// Randomised and directed bench for spi_mode_clk_gen against a cycle-count reference model.
module tb_spi_mode_clk_gen;
    localparam int DIV_W = 8;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_mode_clk_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();
    spi_mode_clk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: edges occur every (D+1) enabled RUN cycles.
    int m_ph = 0, m_act = 0, m_k = 0, m_d = 0, m_n = 0, m_bits = 0;
    bit m_cpol = 0, m_cpha = 0, m_sclk = 0, m_pos = 0, m_neg = 0;
    bit m_samp = 0, m_shift = 0, m_busy = 0, m_done = 0;

    int  edges_seen, samp_seen, shift_seen, done_cyc, start_cyc;
    bit  done_seen;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit lead;
        m_pos = 0; m_neg = 0; m_samp = 0; m_shift = 0;
        if (rst) begin
            m_ph = 0; m_sclk = 0; m_bits = 0; m_k = 0; m_act = 0;
        end else begin
            case (m_ph)
                0: begin
                    m_sclk = bus.i_cpol;
                    if (bus.i_start && bus.i_enable) begin
                        m_d = bus.i_divider; m_n = bus.i_num_bits;
                        m_cpol = bus.i_cpol; m_cpha = bus.i_cpha;
                        m_bits = 0; m_k = 0; m_act = 0;
                        m_ph = (m_n == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (bus.i_abort) begin
                        m_ph = 0; m_sclk = m_cpol;
                    end else if (m_k == 2 * m_n) begin
                        m_ph = 2;
                    end else if (bus.i_enable) begin
                        m_act++;
                        if (m_act % (m_d + 1) == 0) begin
                            m_k++;
                            m_sclk = !m_sclk;
                            m_pos = m_sclk; m_neg = !m_sclk;
                            lead = (m_k % 2) == 1;
                            if (m_cpha) begin
                                m_shift = lead; m_samp = !lead;
                            end else begin
                                m_samp = lead; m_shift = !lead && (m_k < 2 * m_n);
                            end
                            if (m_samp) m_bits++;
                        end
                    end
                end
                default: m_ph = 0;
            endcase
        end
        m_busy = (m_ph == 1);
        m_done = (m_ph == 2);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk_eq("sclk", bus.o_sclk, m_sclk);
        chk_eq("pos_edge", bus.o_pos_edge, m_pos);
        chk_eq("neg_edge", bus.o_neg_edge, m_neg);
        chk_eq("sample", bus.o_sample, m_samp);
        chk_eq("shift", bus.o_shift, m_shift);
        chk_eq("busy", bus.o_busy, m_busy);
        chk_eq("done", bus.o_done, m_done);
        chk_eq("bit_cnt", bus.o_bit_cnt, m_bits);
        if (bus.o_pos_edge || bus.o_neg_edge) edges_seen++;
        if (bus.o_sample) samp_seen++;
        if (bus.o_shift) shift_seen++;
        if (bus.o_done) begin
            done_seen = 1; done_cyc = cyc;
        end
    endtask

    function automatic int exp_lat(input int d, input int n);
        return (n == 0) ? 1 : 2 + d + (2 * n - 1) * (d + 1) + 1;
    endfunction

    task automatic xfer(input int d, input int n, input bit cpol, input bit cpha,
                        input int pause_at, input int pause_len, input int abort_edge,
                        input bit noise, output bit aborted);
        int rel;
        bus.i_divider = d[DIV_W-1:0]; bus.i_num_bits = n[CNT_W-1:0];
        bus.i_cpol = cpol; bus.i_cpha = cpha;
        bus.i_enable = 1; bus.i_start = 1; bus.i_abort = 0;
        edges_seen = 0; samp_seen = 0; shift_seen = 0; done_seen = 0; done_cyc = 0; aborted = 0;
        tick();
        start_cyc = cyc;
        bus.i_start = 0;
        for (int i = 0; i < 4000 && !done_seen && !aborted; i++) begin
            rel = cyc - start_cyc;
            bus.i_enable = !(pause_len > 0 && rel >= pause_at && rel < pause_at + pause_len);
            if (noise) begin
                bus.i_divider = DIV_W'($urandom); bus.i_num_bits = CNT_W'($urandom);
                bus.i_cpol = 1'($urandom); bus.i_cpha = 1'($urandom);
                bus.i_start = ($urandom_range(0, 3) == 0);
            end
            if (abort_edge > 0 && edges_seen == abort_edge) begin
                bus.i_abort = 1;
                tick();
                bus.i_abort = 0;
                aborted = 1;
            end else begin
                tick();
            end
        end
        bus.i_start = 0; bus.i_abort = 0; bus.i_enable = 1;
        chk_eq("xfer_end", done_seen | aborted, 1);
    endtask

    task automatic check_normal(input string tag, input int d, input int n, input bit cpha, input int extra);
        chk_eq({tag, "_edges"}, edges_seen, 2 * n);
        chk_eq({tag, "_samples"}, samp_seen, n);
        chk_eq({tag, "_shifts"}, shift_seen, cpha ? n : (n > 0 ? n - 1 : 0));
        chk_eq({tag, "_bitcnt"}, bus.o_bit_cnt, n);
        chk_eq({tag, "_done_lat"}, done_cyc - start_cyc + 1, exp_lat(d, n) + extra);
    endtask

    initial begin
        bit ab;
        int d, n, plen, pat, aedge;
        rst = 1;
        bus.i_enable = 0; bus.i_start = 0; bus.i_abort = 0;
        bus.i_cpol = 0; bus.i_cpha = 0; bus.i_divider = '0; bus.i_num_bits = '0;
        tick(); tick();
        chk_eq("rst_sclk", bus.o_sclk, 0);
        chk_eq("rst_busy", bus.o_busy, 0);
        rst = 0;
        tick(); tick();

        xfer(0, 8, 0, 0, 0, 0, 0, 0, ab);
        check_normal("m0_d0", 0, 8, 0, 0);
        chk_eq("m0_d0_sclk_end", bus.o_sclk, 0);
        tick(); tick();

        xfer(2, 4, 1, 1, 0, 0, 0, 0, ab);
        check_normal("m3_d2", 2, 4, 1, 0);
        tick(); tick();

        xfer(3, 2, 0, 0, 4, 5, 0, 0, ab);
        check_normal("pause", 3, 2, 0, 5);
        tick(); tick();

        xfer(1, 8, 0, 0, 0, 0, 5, 0, ab);
        chk_eq("abort_bitcnt", bus.o_bit_cnt, 3);
        chk_eq("abort_busy", bus.o_busy, 0);
        chk_eq("abort_sclk", bus.o_sclk, 0);
        tick(); tick(); tick();
        chk_eq("abort_no_done", done_seen, 0);

        xfer(2, 3, 0, 0, 0, 0, 0, 1, ab);
        check_normal("busy_noise", 2, 3, 0, 0);
        tick(); tick();

        xfer(5, 0, 0, 1, 0, 0, 0, 0, ab);
        check_normal("n0", 5, 0, 1, 0);
        tick(); tick();

        // Reset mid-transfer, then a fresh transfer.
        bus.i_divider = 2; bus.i_num_bits = 6; bus.i_cpol = 1; bus.i_cpha = 0;
        bus.i_enable = 1; bus.i_start = 1;
        tick();
        bus.i_start = 0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1;
        tick();
        chk_eq("rst_mid_sclk", bus.o_sclk, 0);
        chk_eq("rst_mid_busy", bus.o_busy, 0);
        chk_eq("rst_mid_bitcnt", bus.o_bit_cnt, 0);
        rst = 0;
        tick();
        xfer(1, 3, 1, 0, 0, 0, 0, 0, ab);
        check_normal("after_rst", 1, 3, 0, 0);
        tick(); tick();

        for (int t = 0; t < 25; t++) begin
            d = $urandom_range(0, 4);
            n = $urandom_range(0, 6);
            plen = 0; pat = 0; aedge = 0;
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                plen = $urandom_range(1, 4);
                if (2 * n * (d + 1) - 1 - plen >= 0) pat = $urandom_range(0, 2 * n * (d + 1) - 1 - plen);
                else plen = 0;
            end
            if (n > 0 && $urandom_range(0, 3) == 0) aedge = $urandom_range(1, 2 * n);
            xfer(d, n, 1'($urandom), 1'($urandom), pat, plen, aedge, 1'($urandom), ab);
            if (!ab) begin
                chk_eq("rnd_edges", edges_seen, 2 * n);
                chk_eq("rnd_samples", samp_seen, n);
                chk_eq("rnd_done_lat", done_cyc - start_cyc + 1, exp_lat(d, n) + plen);
            end else begin
                chk_eq("rnd_abort_busy", bus.o_busy, 0);
            end
            tick(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
